// File: rtl/continuous_monitoring_system_pkg.sv
// Shared definitions for the continuous monitoring system blocks:
// the control register map of the event window aggregator and the
// field widths carried in its trace packets.
package continuous_monitoring_system_pkg;

  typedef enum logic [7:0] {
    AGGR_ENABLE     = 8'h40,
    AGGR_WINDOW_LEN = 8'h41,
    AGGR_EVENT_MASK = 8'h42,
    AGGR_CLEAR      = 8'h43
  } aggr_ctrl_addr_t;

  localparam int AGGR_INDEX_WIDTH = 32;
  localparam int AGGR_DROP_WIDTH  = 32;

endpackage

// File: rtl/cms_sat_counter.sv
// Saturating up-counter: holds at all ones instead of wrapping.
// A clear request takes priority over an increment.
module cms_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: clear wins, otherwise increment until all ones.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cms_event_window_aggregator.sv
// Event window aggregator: counts performance-event bits per channel over
// a programmable window of enabled cycles and, when a window closes, emits
// one AXI-Stream packet with all counters, the closing pc and the window
// index. One registered output slot; a snapshot arriving while the slot is
// stalled is discarded.
// Optional build macro CMS_AGGR_DROP_COUNTER_EN adds a saturating count of
// discarded snapshots to every packet.
module cms_event_window_aggregator
  import continuous_monitoring_system_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int NUM_EVENTS     = 16,
  parameter int COUNTER_WIDTH  = 16,
  parameter int AXI_DATA_WIDTH = 1024,
  parameter int DEFAULT_WINDOW = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [XLEN-1:0]           pc,
  input  logic                      pc_valid,
  input  logic [NUM_EVENTS-1:0]     performance_events,
  input  aggr_ctrl_addr_t           ctrl_addr,
  input  logic [63:0]               ctrl_wdata,
  input  logic                      ctrl_write_enable,
  output logic                      M_AXIS_tvalid,
  input  logic                      M_AXIS_tready,
  output logic [AXI_DATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                      M_AXIS_tlast,
  input  logic [31:0]               tlast_interval
);

  localparam int P = NUM_EVENTS * COUNTER_WIDTH;

  if (AXI_DATA_WIDTH < P + XLEN + 64) begin : g_width_check
    $error("AXI_DATA_WIDTH too small for counters, pc, index and drop fields");
  end
  if (NUM_EVENTS < 1 || NUM_EVENTS > 64) begin : g_events_check
    $error("NUM_EVENTS must be in 1..64");
  end

  logic                  enable_q, enable_d;
  logic [31:0]           window_len_q, window_len_d;
  logic [NUM_EVENTS-1:0] mask_q, mask_d;
  logic                  clear_wr;

  logic [31:0]                 cycle_q, cycle_d;
  logic [AGGR_INDEX_WIDTH-1:0] win_idx_q, win_idx_d;
  logic [31:0]                 frame_q, frame_d;

  logic                      tvalid_q, tvalid_d;
  logic [AXI_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                      tlast_q, tlast_d;

  logic [NUM_EVENTS-1:0]                    inc;
  logic [NUM_EVENTS-1:0][COUNTER_WIDTH-1:0] cnt;
  logic [NUM_EVENTS-1:0][COUNTER_WIDTH-1:0] snap;
  logic [AXI_DATA_WIDTH-1:0]                pkt;

  logic close, handshake, load, drop, tlast_new;

  // Control register writes; clear is a one-cycle strobe.
  always_comb begin
    enable_d     = enable_q;
    window_len_d = window_len_q;
    mask_d       = mask_q;
    clear_wr     = 1'b0;
    if (ctrl_write_enable) begin
      case (ctrl_addr)
        AGGR_ENABLE:     enable_d     = ctrl_wdata[0];
        AGGR_WINDOW_LEN: window_len_d = ctrl_wdata[31:0];
        AGGR_EVENT_MASK: mask_d       = ctrl_wdata[NUM_EVENTS-1:0];
        AGGR_CLEAR:      clear_wr     = 1'b1;
        default:         ;
      endcase
    end
  end

  // A zero window length never closes, so counters free-run.
  assign close = enable_q && (window_len_q != 32'd0) &&
                 (cycle_q == window_len_q - 32'd1);

  assign inc = (enable_q && pc_valid) ? (performance_events & mask_q) : '0;

  for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_ch
    cms_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (clear_wr | close),
      .inc   (inc[i]),
      .count (cnt[i])
    );
  end

  // Snapshot includes this cycle's events so the closing cycle counts in its own window.
  always_comb begin
    for (int i = 0; i < NUM_EVENTS; i++) begin
      snap[i] = (inc[i] && (cnt[i] != '1)) ? cnt[i] + COUNTER_WIDTH'(1) : cnt[i];
    end
  end

`ifdef CMS_AGGR_DROP_COUNTER_EN
  logic [AGGR_DROP_WIDTH-1:0] drop_q, drop_d;

  // Saturating count of discarded snapshots; an AGGR_CLEAR write resets it.
  always_comb begin
    drop_d = drop_q;
    if (clear_wr) begin
      drop_d = '0;
    end else if (drop && (drop_q != '1)) begin
      drop_d = drop_q + AGGR_DROP_WIDTH'(1);
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  // Packet assembly; fields not listed stay zero.
  always_comb begin
    pkt = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      pkt[i*COUNTER_WIDTH +: COUNTER_WIDTH] = snap[i];
    end
    pkt[P +: XLEN]                    = pc;
    pkt[P+XLEN +: AGGR_INDEX_WIDTH]   = win_idx_q;
`ifdef CMS_AGGR_DROP_COUNTER_EN
    pkt[P+XLEN+32 +: AGGR_DROP_WIDTH] = drop_q;
`endif
  end

  assign handshake = tvalid_q && M_AXIS_tready;
  assign load      = close && (!tvalid_q || M_AXIS_tready);
  assign drop      = close && tvalid_q && !M_AXIS_tready;

  // Window timing, frame position and output slot next state.
  always_comb begin
    cycle_d = cycle_q;
    if (clear_wr || close) begin
      cycle_d = '0;
    end else if (enable_q) begin
      cycle_d = cycle_q + 32'd1;
    end

    win_idx_d = close ? win_idx_q + AGGR_INDEX_WIDTH'(1) : win_idx_q;

    frame_d = frame_q;
    if (handshake) begin
      frame_d = tlast_q ? 32'd0 : frame_q + 32'd1;
    end

    // The >= comparison ends an overlong frame when tlast_interval shrinks.
    tlast_new = (tlast_interval <= 32'd1) || (frame_d >= tlast_interval - 32'd1);

    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    if (load) begin
      tvalid_d = 1'b1;
      tdata_d  = pkt;
      tlast_d  = tlast_new;
    end else if (handshake) begin
      tvalid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q     <= 1'b0;
      window_len_q <= 32'(DEFAULT_WINDOW);
      mask_q       <= '1;
      cycle_q      <= '0;
      win_idx_q    <= '0;
      frame_q      <= '0;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tlast_q      <= 1'b0;
    end else begin
      enable_q     <= enable_d;
      window_len_q <= window_len_d;
      mask_q       <= mask_d;
      cycle_q      <= cycle_d;
      win_idx_q    <= win_idx_d;
      frame_q      <= frame_d;
      tvalid_q     <= tvalid_d;
      tdata_q      <= tdata_d;
      tlast_q      <= tlast_d;
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^ctrl_wdata[63:32];

  assign M_AXIS_tvalid = tvalid_q;
  assign M_AXIS_tdata  = tdata_q;
  assign M_AXIS_tlast  = tlast_q;

endmodule
